vga_pixel_pio_multi: RTL and testbench
======================================

# vga_pixel_pio_multi

Parametrised Avalon-MM slave input port for the VGA image viewer, successor to the single-channel pixel-data input port. Samples CHANNELS independent WIDTH-bit input buses and exposes each as a readable data register. Adds per-bit edge capture, per-channel interrupt masking, write-1-to-clear semantics and a single level interrupt to the Nios II. Sits on the system interconnect between the pixel source logic and the CPU data master.

## Interface
- WIDTH, 32, bits per channel (1..32); readdata bits above WIDTH read 0
- CHANNELS, 2, number of input channels (1..8)
- EDGE_MODE, 0, capture condition: 0 rising, 1 falling, 2 any edge
- AW, derived, address width = 2 + clog2(CHANNELS), minimum 2
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  AW  word address; [AW-1:2] = channel index, [1:0] = register
- write  input  1  write strobe, single cycle
- writedata  input  32  write data
- in_port  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- readdata  output  32  registered read data
- irq  output  1  level interrupt, registered

## Operation
- Register map per channel (offset [1:0]): 0 data (RO), 1 irqmask (RW), 2 edgecapture (RW1C), 3 reserved (reads 0, writes ignored).
- Channel index ≥ CHANNELS: reads 0, writes ignored.
- Sampled value s[c]: output of input stage (see Configuration). Previous value p[c] registered from s[c] every cycle.
- Edge detect per bit: rising = s & ~p; falling = ~s & p; any = s ^ p; selected by EDGE_MODE.
- edgecapture[c] bit sets on detected edge, stays set until cleared by writing 1 to that bit at offset 2. Writing 0 has no effect.
- Set and clear on the same bit in the same cycle: set wins (bit remains 1).
- irqmask[c] written with writedata[WIDTH-1:0] at offset 1; readback returns last written value.
- irq next = OR over all channels of |(edgecapture[c] & irqmask[c]).
- Writes to offset 0 ignored.

## Timing
- Reset values: readdata 0, irq 0, all irqmask 0, all edgecapture 0, p 0, synchroniser stages 0.
- Reset asserted mid-operation: all state cleared on assertion regardless of clk; edges present at release are detected from p = 0 (a high input after reset produces a rising-edge capture on the first sample).
- readdata updated every clk from current address (no read strobe); valid one cycle after address presented, as for the predecessor port.
- Read of edgecapture in the same cycle as a clearing write returns the pre-write value.
- Input-to-data latency: 2 clk with synchroniser, 0 clk into read mux (readdata +1) without.
- Edge-to-edgecapture: edgecapture bit visible one clk after s changes; irq asserts one clk after that.
- irq deasserts one clk after the clearing write or after a mask write removing the last enabled captured bit.
- Write takes effect on the clk edge where write is high; no wait states.

## Configuration
- Macro PIXEL_PIO_SYNC_EN.
- Defined: each in_port bit passes through a two-flop synchroniser before s; safe for asynchronous pixel sources.
- Undefined: s = in_port directly; in_port must be synchronous to clk. p and edge logic unchanged.

## Test plan
- Reset: assert reset mid-run with edgecapture ch0 = 0x0000_00FF, irqmask 0xFF -> readdata, irq, edgecapture, irqmask all 0 immediately, without waiting for clk.
- Data read: CHANNELS=2, WIDTH=16, in_port = 0xBEEF_1234 -> read addr 0 returns 0x0000_1234, addr 4 returns 0x0000_BEEF, with stated latency per PIXEL_PIO_SYNC_EN.
- Rising capture and irq: EDGE_MODE 0, irqmask ch1 = 0x0001, bit 16 of in_port 0->1 -> edgecapture ch1 (addr 6) = 0x0001, irq = 1; write 0x0001 to addr 6 -> irq 0 next cycle, readback 0.
- Masking: edge on ch0 bit 3 with irqmask ch0 = 0 -> edgecapture 0x0008, irq stays 0; write irqmask 0x0008 -> irq 1 one cycle later.
- Set-vs-clear collision: write 0x0008 to addr 2 in same cycle as a new rising edge on bit 3 -> edgecapture bit 3 remains 1.
- EDGE_MODE 2 / out-of-range: bit toggles 0->1->0 -> captured on each edge after clear; read channel index 2 with CHANNELS=2 -> 0, write there changes nothing.

Source files
------------

// File: rtl/vga_pixel_pio_multi.sv
// vga_pixel_pio_multi
//
// Multi-channel Avalon-MM input port for the VGA image viewer. It samples
// CHANNELS independent WIDTH-bit input buses. Each channel provides a data
// register, an interrupt mask, and per-bit edge capture with write-1-to-clear.
// One level interrupt goes to the CPU.
//
// Parameters
//   WIDTH      bits per channel (1..32); readdata bits above WIDTH read 0
//   CHANNELS   number of input channels (1..8)
//   EDGE_MODE  capture condition: 0 rising, 1 falling, 2 any edge
//   AW         derived word-address width, 2 + clog2(CHANNELS), minimum 2
//
// Configuration macro
//   PIXEL_PIO_SYNC_EN  when defined, every in_port bit passes through a
//                      two-flop synchroniser before it is sampled. When it is
//                      undefined, in_port must be synchronous to clk.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   address    word address: [AW-1:2] channel index, [1:0] register offset
//   write      single-cycle write strobe
//   writedata  32-bit write data
//   in_port    channel c occupies bits [c*WIDTH +: WIDTH]
//   readdata   registered read data
//   irq        registered level interrupt
//
// Register map per channel (offset [1:0])
//   0 data (RO), 1 irqmask (RW), 2 edgecapture (RW1C), 3 reserved (reads 0)
//   A channel index >= CHANNELS reads 0, and writes to it are ignored.
//
// Bus timing: the port has no handshake and never inserts wait states. A write
// is taken on the clk edge where write is high. readdata is reloaded on every
// clk edge from the address present at that edge, so read data is valid one
// cycle after the address is presented.

module vga_pixel_pio_multi #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int EDGE_MODE = 0,
  localparam int AW       = (CHANNELS > 1) ? 2 + $clog2(CHANNELS) : 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW-1:0]             address,
  input  logic                      write,
  input  logic [31:0]               writedata,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic [31:0]               readdata,
  output logic                      irq
);

  typedef logic [CHANNELS-1:0][WIDTH-1:0] chan_vec_t;

  chan_vec_t           s;         // sampled input
  chan_vec_t           p;         // previous sample
  chan_vec_t           edge_det;
  chan_vec_t           edge_cap;
  chan_vec_t           irq_mask;
  chan_vec_t           clr_bits;  // write-1-to-clear bits for this cycle
  logic [CHANNELS-1:0] mask_we;
  logic [31:0]         chan_idx;
  logic [1:0]          reg_off;
  logic [31:0]         rd_mux;

  // Not every writedata bit lands in a register when WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

`ifdef PIXEL_PIO_SYNC_EN
  chan_vec_t sync_q1;
  chan_vec_t sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = in_port;
`endif

  // When there is only one channel, no address bits are left for the index.
  generate
    if (AW > 2) begin : g_idx
      assign chan_idx = 32'(address[AW-1:2]);
    end else begin : g_idx_single
      assign chan_idx = 32'd0;
    end
  endgenerate

  assign reg_off = address[1:0];

  always_comb begin
    edge_det = '0;
    case (EDGE_MODE)
      0:       edge_det = s & ~p;
      1:       edge_det = ~s & p;
      default: edge_det = s ^ p;
    endcase
  end

  // If the index is out of range, no channel matches, so the write falls away.
  always_comb begin
    mask_we  = '0;
    clr_bits = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (write && (chan_idx == 32'(c))) begin
        if (reg_off == 2'd1) mask_we[c] = 1'b1;
        if (reg_off == 2'd2) clr_bits[c] = writedata[WIDTH-1:0];
      end
    end
  end

  // The mux reads the register values from before the edge. A read that
  // coincides with a clearing write therefore returns the value it had before
  // that write.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_idx == 32'(c)) begin
        case (reg_off)
          2'd0:    rd_mux = 32'(s[c]);
          2'd1:    rd_mux = 32'(irq_mask[c]);
          2'd2:    rd_mux = 32'(edge_cap[c]);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p        <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      p        <= s;
      // The edge is ORed in after the clear, so a new edge wins a collision.
      edge_cap <= (edge_cap & ~clr_bits) | edge_det;
      for (int c = 0; c < CHANNELS; c++) begin
        if (mask_we[c]) irq_mask[c] <= writedata[WIDTH-1:0];
      end
      readdata <= rd_mux;
      irq      <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_vga_pixel_pio_multi.sv
// Testbench for vga_pixel_pio_multi. It drives two instances:
//   dut_a: WIDTH=16, CHANNELS=2, EDGE_MODE=0 (rising)
//   dut_b: WIDTH=8,  CHANNELS=3, EDGE_MODE=2 (any edge; index 3 is out of range)
// Each expected value is pushed into a queue when its stimulus is issued. A
// monitor pops and compares one cycle later, and immediately for the reset
// checks.

module tb_vga_pixel_pio_multi;

`ifdef PIXEL_PIO_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address_a;
  logic        write_a;
  logic [31:0] writedata_a;
  logic [31:0] in_a;
  logic [31:0] readdata_a;
  logic        irq_a;
  logic [3:0]  address_b;
  logic        write_b;
  logic [31:0] writedata_b;
  logic [23:0] in_b;
  logic [31:0] readdata_b;
  logic        irq_b;

  always #5 clk = ~clk;

  vga_pixel_pio_multi #(.WIDTH(16), .CHANNELS(2), .EDGE_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .address(address_a), .write(write_a),
    .writedata(writedata_a), .in_port(in_a), .readdata(readdata_a), .irq(irq_a)
  );

  vga_pixel_pio_multi #(.WIDTH(8), .CHANNELS(3), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset(reset), .address(address_b), .write(write_b),
    .writedata(writedata_b), .in_port(in_b), .readdata(readdata_b), .irq(irq_b)
  );

  // ---------------- scoreboard ----------------
  // kinds: 0 readdata_a, 1 readdata_b, 2 irq_a, 3 irq_b (checked one cycle on)
  //        4 readdata_a, 5 irq_a (checked immediately)
  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        chk_req = 1'b0;
  logic        chk_live = 1'b0;
  logic        imm_req = 1'b0;

  always @(posedge clk) chk_live <= chk_req;

  task automatic compare_front();
    logic [31:0] e;
    logic [31:0] a;
    int          k;
    string       n;
    e = exp_q.pop_front();
    k = kind_q.pop_front();
    n = name_q.pop_front();
    case (k)
      0, 4:    a = readdata_a;
      1:       a = readdata_b;
      2, 5:    a = {31'd0, irq_a};
      default: a = {31'd0, irq_b};
    endcase
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge imm_req);
      if (imm_req) begin
        while (kind_q.size() > 0 && kind_q[0] >= 4) compare_front();
      end else if (chk_live) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got empty queue expected an entry");
        end else begin
          compare_front();
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_in   [2];
  logic [31:0] m_cap  [2][8];
  logic [31:0] m_mask [2][8];

  function automatic int dwid(int d);  return (d == 0) ? 16 : 8; endfunction
  function automatic int dch(int d);   return (d == 0) ? 2 : 3;  endfunction
  function automatic int dmode(int d); return (d == 0) ? 0 : 2;  endfunction
  function automatic logic [31:0] wm(int d);
    return (d == 0) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 8; c++) begin
        m_cap[d][c]  = 32'd0;
        m_mask[d][c] = 32'd0;
      end
  endfunction

  function automatic void apply_edges(int d, logic [31:0] old_v, logic [31:0] new_v);
    logic [31:0] e;
    e = (dmode(d) == 0) ? (new_v & ~old_v) : (new_v ^ old_v);
    for (int c = 0; c < dch(d); c++)
      m_cap[d][c] = m_cap[d][c] | ((e >> (c * dwid(d))) & wm(d));
  endfunction

  function automatic void model_write(int d, int addr, logic [31:0] data);
    int ch;
    int off;
    ch  = addr / 4;
    off = addr % 4;
    if (ch < dch(d)) begin
      if (off == 1) m_mask[d][ch] = data & wm(d);
      if (off == 2) m_cap[d][ch]  = m_cap[d][ch] & ~data;
    end
  endfunction

  function automatic logic [31:0] ref_read(int d, int addr);
    int ch;
    int off;
    ch  = addr / 4;
    off = addr % 4;
    ref_read = 32'd0;
    if (ch < dch(d)) begin
      case (off)
        0:       ref_read = (m_in[d] >> (ch * dwid(d))) & wm(d);
        1:       ref_read = m_mask[d][ch];
        2:       ref_read = m_cap[d][ch];
        default: ref_read = 32'd0;
      endcase
    end
  endfunction

  function automatic logic ref_irq(int d);
    ref_irq = 1'b0;
    for (int c = 0; c < dch(d); c++)
      if ((m_cap[d][c] & m_mask[d][c]) != 32'd0) ref_irq = 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic push(int k, logic [31:0] e, string n);
    exp_q.push_back(e);
    kind_q.push_back(k);
    name_q.push_back(n);
  endtask

  task automatic rd(int d, int addr, logic [31:0] e, string n);
    if (d == 0) address_a = 3'(addr);
    else        address_b = 4'(addr);
    push(d, e, n);
    chk_req = 1'b1;
    step();
  endtask

  task automatic irq_chk(int d, logic e, string n);
    push(d + 2, {31'd0, e}, n);
    chk_req = 1'b1;
    step();
  endtask

  task automatic wr(int d, int addr, logic [31:0] data);
    if (d == 0) begin
      address_a = 3'(addr); writedata_a = data; write_a = 1'b1;
    end else begin
      address_b = 4'(addr); writedata_b = data; write_b = 1'b1;
    end
    step();
    write_a = 1'b0;
    write_b = 1'b0;
    model_write(d, addr, data);
  endtask

  task automatic drive_in(int d, logic [31:0] val);
    if (d == 0) in_a = val;
    else        in_b = val[23:0];
  endtask

  // Change an input and wait until the capture and the irq have settled.
  task automatic set_input(int d, logic [31:0] val);
    drive_in(d, val);
    repeat (SYNC + 2) step();
    apply_edges(d, m_in[d], val);
    m_in[d] = val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    address_a = '0; write_a = 1'b0; writedata_a = '0; in_a = '0;
    address_b = '0; write_b = 1'b0; writedata_b = '0; in_b = '0;
    m_in[0] = 32'd0;
    m_in[1] = 32'd0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;

    irq_chk(0, 1'b0, "reset_irq_a");
    irq_chk(1, 1'b0, "reset_irq_b");
    rd(0, 1, 32'd0, "reset_mask_a");
    rd(0, 2, 32'd0, "reset_cap_a");
    rd(1, 6, 32'd0, "reset_cap_b1");

    // Data read with latency: 0 into mux without synchroniser, 2 with it.
    in_a = 32'hBEEF_1234;
    for (int i = 0; i <= SYNC; i++)
      rd(0, 0, (i == SYNC) ? 32'h0000_1234 : 32'h0000_0000, "data_latency_ch0");
    rd(0, 4, 32'h0000_BEEF, "data_ch1");
    apply_edges(0, 32'd0, 32'hBEEF_1234);
    m_in[0] = 32'hBEEF_1234;
    rd(0, 2, ref_read(0, 2), "cap_after_data_ch0");
    wr(0, 2, 32'h0000_FFFF);
    wr(0, 6, 32'h0000_FFFF);
    rd(0, 6, 32'd0, "cap_clr_all_ch1");

    // Rising capture on bit 16 with irqmask ch1 = 1, checked at exact latency.
    set_input(0, 32'd0);
    wr(0, 5, 32'h0000_0001);
    in_a = 32'h0001_0000;
    repeat (SYNC) step();
    irq_chk(0, 1'b0, "irq_before_capture");
    irq_chk(0, 1'b1, "irq_rise");
    apply_edges(0, 32'd0, 32'h0001_0000);
    m_in[0] = 32'h0001_0000;
    rd(0, 6, 32'h0000_0001, "cap_rise_ch1");
    rd(0, 5, 32'h0000_0001, "mask_readback_ch1");
    // Clearing write and read in the same cycle: the read returns the old value.
    write_a = 1'b1; writedata_a = 32'h0000_0001;
    rd(0, 6, 32'h0000_0001, "cap_read_during_clear");
    write_a = 1'b0;
    model_write(0, 6, 32'h0000_0001);
    irq_chk(0, 1'b0, "irq_after_clear");
    rd(0, 6, 32'd0, "cap_cleared_ch1");

    // Masking.
    set_input(0, 32'h0001_0008);
    rd(0, 2, 32'h0000_0008, "cap_masked_ch0");
    irq_chk(0, 1'b0, "irq_masked");
    wr(0, 1, 32'h0000_0008);
    irq_chk(0, 1'b1, "irq_unmasked");
    wr(0, 1, 32'h0000_0000);
    irq_chk(0, 1'b0, "irq_mask_removed");

    // A clear and a new edge on bit 3 in the same cycle: the set wins.
    set_input(0, 32'h0001_0000);
    in_a = 32'h0001_0008;
    repeat (SYNC) step();
    address_a = 3'd2; writedata_a = 32'h0000_0008; write_a = 1'b1;
    step();
    write_a = 1'b0;
    m_cap[0][0] = (m_cap[0][0] & ~32'h8) | 32'h8;
    m_in[0] = 32'h0001_0008;
    rd(0, 2, 32'h0000_0008, "cap_collision_set_wins");
    wr(0, 2, 32'h0000_0008);
    rd(0, 2, 32'd0, "cap_clear_ch0");

    // Asynchronous reset while the capture is active.
    set_input(0, 32'h0001_0000);
    set_input(0, 32'h0001_00FF);
    wr(0, 1, 32'h0000_00FF);
    irq_chk(0, 1'b1, "irq_pre_reset");
    rd(0, 2, 32'h0000_00FF, "cap_pre_reset");
    step();
    reset = 1'b1;
    #1;
    push(4, 32'd0, "reset_async_readdata");
    push(5, 32'd0, "reset_async_irq");
    imm_req = 1'b1;
    #1;
    imm_req = 1'b0;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    apply_edges(0, 32'd0, m_in[0]);
    apply_edges(1, 32'd0, m_in[1]);
    repeat (SYNC + 2) step();
    rd(0, 1, 32'd0, "mask_after_reset");
    rd(0, 2, 32'h0000_00FF, "cap_rise_after_reset_ch0");
    rd(0, 6, 32'h0000_0001, "cap_rise_after_reset_ch1");
    irq_chk(0, 1'b0, "irq_after_reset");

    // Any-edge mode on dut_b, then the out-of-range channel.
    set_input(1, 32'h0000_0001);
    rd(1, 2, 32'h0000_0001, "any_edge_rise");
    wr(1, 2, 32'h0000_0001);
    rd(1, 2, 32'd0, "any_edge_cleared");
    set_input(1, 32'h0000_0000);
    rd(1, 2, 32'h0000_0001, "any_edge_fall");
    wr(1, 2, 32'h0000_0001);
    set_input(1, 32'h00FF_FFFF);
    rd(1, 12, 32'd0, "oob_read_data");
    wr(1, 13, 32'h0000_00FF);
    wr(1, 14, 32'hFFFF_FFFF);
    wr(1, 3, 32'h0000_00FF);
    wr(1, 0, 32'd0);
    rd(1, 13, 32'd0, "oob_read_mask");
    rd(1, 14, 32'd0, "oob_read_cap");
    rd(1, 3, 32'd0, "reserved_read");
    rd(1, 0, 32'h0000_00FF, "data_write_ignored");
    rd(1, 9, ref_read(1, 9), "mask_ch2_untouched");
    rd(1, 10, ref_read(1, 10), "cap_ch2_untouched");
    rd(1, 8, 32'h0000_00FF, "data_ch2");

    // Randomised phase against the model.
    for (int it = 0; it < 80; it++) begin
      int          d;
      int          act;
      int          addr;
      logic [31:0] v;
      d   = $urandom_range(0, 1);
      act = $urandom_range(0, 2);
      if (act == 0) begin
        v = $urandom;
        v = (d == 0) ? v : (v & 32'h00FF_FFFF);
        set_input(d, v);
        irq_chk(d, ref_irq(d), "rand_irq_after_input");
      end else if (act == 1) begin
        addr = $urandom_range(0, (d == 0) ? 7 : 15);
        v    = $urandom;
        wr(d, addr, v);
        irq_chk(d, ref_irq(d), "rand_irq_after_write");
      end else begin
        addr = $urandom_range(0, (d == 0) ? 7 : 15);
        rd(d, addr, ref_read(d, addr), "rand_read");
      end
    end

    step();
    step();
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
